// File: rtl/lsu_dispatch_buffer.sv
// In-order memory-op dispatch buffer: ops enter by tag, get their address/data
// resolved in any order, and leave oldest-first through a two-phase issue handshake.
module lsu_dispatch_buffer #(
   parameter int TAG_WIDTH = 10,
   parameter int DEPTH     = 4
) (
   input  logic                     clk,
   input  logic                     rst_N,
   input  logic                     disp_valid,
   input  logic [TAG_WIDTH-1:0]     disp_tag,
   input  logic                     disp_is_write,
   output logic                     disp_ready,
   input  logic                     agen_valid,
   input  logic [TAG_WIDTH-1:0]     agen_tag,
   input  logic [63:0]              agen_addr,
   input  logic [63:0]              agen_value,
   output logic                     agen_err,
   output logic                     lsu_proc_instr_valid,
   output logic [TAG_WIDTH-1:0]     lsu_proc_instr_tag,
   output logic                     lsu_proc_instr_is_write,
   input  logic                     lsu_proc_instr_ready,
   output logic                     lsu_proc_data_valid,
   output logic [TAG_WIDTH-1:0]     lsu_proc_data_tag,
   output logic [63:0]              lsu_proc_addr,
   output logic [63:0]              lsu_proc_value,
   input  logic                     lsu_proc_data_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_INSTR, S_DATA} state_t;

   logic                 r_valid    [DEPTH];
   logic                 r_resolved [DEPTH];
   logic                 r_is_write [DEPTH];
   logic [TAG_WIDTH-1:0] r_tag      [DEPTH];
   logic [63:0]          r_addr     [DEPTH];
   logic [63:0]          r_value    [DEPTH];
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;
   state_t               r_state;
   state_t               w_state_next;

   logic                 r_agen_err;
   logic                 r_instr_valid;
   logic [TAG_WIDTH-1:0] r_instr_tag;
   logic                 r_instr_wr;
   logic                 r_data_valid;
   logic [TAG_WIDTH-1:0] r_data_tag;
   logic [63:0]          r_addr_out;
   logic [63:0]          r_value_out;

   logic                 w_instr_valid_next;
   logic [TAG_WIDTH-1:0] w_instr_tag_next;
   logic                 w_instr_wr_next;
   logic                 w_data_valid_next;
   logic [TAG_WIDTH-1:0] w_data_tag_next;
   logic [63:0]          w_addr_next;
   logic [63:0]          w_value_next;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_head_ready;
   logic [DEPTH-1:0]     w_hit;
   logic                 w_agen_hit;
   logic [PTR_W-1:0]     w_agen_idx;

   assign disp_ready   = (r_count < CNT_W'(DEPTH));
   assign w_push       = disp_valid && disp_ready;
   assign w_pop        = (r_state == S_DATA) && lsu_proc_data_ready;
   assign w_head_ready = r_valid[r_head] && r_resolved[r_head];

   // w_hit is ordered by age: bit 0 is the head, bit DEPTH-1 the youngest slot.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hit
         logic [PTR_W-1:0] w_idx;
         assign w_idx     = r_head + PTR_W'(gi);
         assign w_hit[gi] = r_valid[w_idx] && !r_resolved[w_idx] && (r_tag[w_idx] == agen_tag);
      end
   endgenerate

   always_comb begin
      w_agen_hit = 1'b0;
      w_agen_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_agen_hit = 1'b1;
            w_agen_idx = r_head + PTR_W'(i);
         end
      end
   end

   // Push, resolve and pop never target the same slot in one cycle:
   // push needs a free tail, resolve needs an unresolved entry, pop a resolved head.
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_valid[i]    <= 1'b0;
            r_resolved[i] <= 1'b0;
            r_is_write[i] <= 1'b0;
            r_tag[i]      <= '0;
            r_addr[i]     <= '0;
            r_value[i]    <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_valid[r_tail]    <= 1'b1;
            r_resolved[r_tail] <= 1'b0;
            r_is_write[r_tail] <= disp_is_write;
            r_tag[r_tail]      <= disp_tag;
            r_addr[r_tail]     <= '0;
            r_value[r_tail]    <= '0;
            r_tail             <= r_tail + PTR_W'(1);
         end
         if (agen_valid && w_agen_hit) begin
            r_resolved[w_agen_idx] <= 1'b1;
            r_addr[w_agen_idx]     <= agen_addr;
            r_value[w_agen_idx]    <= r_is_write[w_agen_idx] ? agen_value : 64'd0;
         end
         if (w_pop) begin
            r_valid[r_head]    <= 1'b0;
            r_resolved[r_head] <= 1'b0;
            r_head             <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_instr_valid_next = 1'b0;
      w_instr_tag_next   = '0;
      w_instr_wr_next    = 1'b0;
      w_data_valid_next  = 1'b0;
      w_data_tag_next    = '0;
      w_addr_next        = '0;
      w_value_next       = '0;
      case (r_state)
         S_IDLE:  if (w_head_ready)         w_state_next = S_INSTR;
         S_INSTR: if (lsu_proc_instr_ready) w_state_next = S_DATA;
         S_DATA:  if (lsu_proc_data_ready)  w_state_next = S_IDLE;
         default:                           w_state_next = S_IDLE;
      endcase
      // Head is frozen from INSTR entry until its pop, so the payload stays stable.
      if (w_state_next == S_INSTR) begin
         w_instr_valid_next = 1'b1;
         w_instr_tag_next   = r_tag[r_head];
         w_instr_wr_next    = r_is_write[r_head];
      end
      if (w_state_next == S_DATA) begin
         w_data_valid_next = 1'b1;
         w_data_tag_next   = r_tag[r_head];
         w_addr_next       = r_addr[r_head];
         w_value_next      = r_value[r_head];
      end
   end

   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         r_state       <= S_IDLE;
         r_agen_err    <= 1'b0;
         r_instr_valid <= 1'b0;
         r_instr_tag   <= '0;
         r_instr_wr    <= 1'b0;
         r_data_valid  <= 1'b0;
         r_data_tag    <= '0;
         r_addr_out    <= '0;
         r_value_out   <= '0;
      end else begin
         r_state       <= w_state_next;
         r_agen_err    <= agen_valid && !w_agen_hit;
         r_instr_valid <= w_instr_valid_next;
         r_instr_tag   <= w_instr_tag_next;
         r_instr_wr    <= w_instr_wr_next;
         r_data_valid  <= w_data_valid_next;
         r_data_tag    <= w_data_tag_next;
         r_addr_out    <= w_addr_next;
         r_value_out   <= w_value_next;
      end
   end

   assign agen_err                = r_agen_err;
   assign lsu_proc_instr_valid    = r_instr_valid;
   assign lsu_proc_instr_tag      = r_instr_tag;
   assign lsu_proc_instr_is_write = r_instr_wr;
   assign lsu_proc_data_valid     = r_data_valid;
   assign lsu_proc_data_tag       = r_data_tag;
   assign lsu_proc_addr           = r_addr_out;
   assign lsu_proc_value          = r_value_out;
   assign occupancy               = r_count;

endmodule

// File: doc/lsu_dispatch_buffer.md
LSU_DISPATCH_BUFFER -- requirements
Module: lsu_dispatch_buffer

Interface
REQ-001 Parameters SHALL be:
- TAG_WIDTH, default 10, instruction tag width.
- DEPTH, default 4, number of buffer entries, power of two, at least 2.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all state on rising edge.
- rst_N  in  1  asynchronous active-low reset.
- disp_valid  in  1  processor dispatches a memory op.
- disp_tag  in  TAG_WIDTH  tag of the dispatched op.
- disp_is_write  in  1  1 = store, 0 = load.
- disp_ready  out  1  buffer can accept a dispatch.
- agen_valid  in  1  address/data for a previously dispatched tag.
- agen_tag  in  TAG_WIDTH  tag being resolved.
- agen_addr  in  64  effective address.
- agen_value  in  64  store data; ignored for loads.
- agen_err  out  1  one-cycle pulse: agen_valid had no matching unresolved entry.
- lsu_proc_instr_valid  out  1  instruction phase to memory subsystem.
- lsu_proc_instr_tag  out  TAG_WIDTH  instruction phase tag.
- lsu_proc_instr_is_write  out  1  instruction phase write flag.
- lsu_proc_instr_ready  in  1  memory subsystem accepts instruction phase.
- lsu_proc_data_valid  out  1  data phase to memory subsystem.
- lsu_proc_data_tag  out  TAG_WIDTH  data phase tag.
- lsu_proc_addr  out  64  data phase address.
- lsu_proc_value  out  64  data phase store value.
- lsu_proc_data_ready  in  1  memory subsystem accepts data phase.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-003 The buffer SHALL be a circular FIFO of DEPTH entries, each holding {valid, resolved, tag, is_write, addr, value}, with head/tail pointers that wrap modulo DEPTH.
REQ-004 disp_ready SHALL equal (occupancy < DEPTH), derived from registered state only; a dispatch is accepted when disp_valid && disp_ready and is written at tail with resolved=0.
REQ-005 Full boundary: a pop in the same cycle does not raise disp_ready; dispatch while full is not accepted and changes no state.
REQ-006 agen_valid SHALL search all valid, unresolved entries for agen_tag; the oldest match (closest to head) gets addr/value and resolved=1 at the next edge.
REQ-007 No match (tag absent, already resolved, or dispatched in the same cycle) SHALL drop the agen and pulse agen_err high for exactly the following cycle.
REQ-008 Entries SHALL be issued strictly in dispatch order; a resolved non-head entry waits for the head.
REQ-009 Issue FSM states SHALL be:
- IDLE: if head valid && resolved, go to INSTR.
- INSTR: assert lsu_proc_instr_valid with head tag/is_write; on lsu_proc_instr_ready go to DATA.
- DATA: assert lsu_proc_data_valid with head tag/addr/value; on lsu_proc_data_ready pop head, return to IDLE.
REQ-010 Issue outputs SHALL be registered; valid SHALL hold with stable payload until the handshake completes.
REQ-011 Minimum latency: an agen resolving the head at edge N with FSM in IDLE gives instr_valid high after edge N+1; with zero-wait ready, the pop occurs at edge N+3.
REQ-012 Simultaneous dispatch and pop SHALL leave occupancy unchanged; dispatch, agen and pop in one cycle SHALL all take effect.
REQ-013 Payload outputs SHALL be 0 whenever the corresponding valid is low.

Reset
REQ-014 While rst_N is low (asynchronous assertion):
- All entries invalid; head = tail = 0; FSM in IDLE.
- occupancy = 0; disp_ready = 1; agen_err = 0; all lsu_proc_* outputs 0.
- Behaviour is identical if reset arrives mid-handshake; the in-flight op is discarded.
REQ-015 Reset deassertion SHALL take effect on the first rising edge after rst_N goes high.

Verification
REQ-016 The bench SHALL cover:
- Store, zero-wait: dispatch tag 10 write; agen tag 10, addr 0x1000, value 0xDEADBEEFCAFEF00D -> instr phase then data phase with these values; pop at N+3; occupancy returns to 0.
- Out-of-order agen: dispatch tags 20, 21, 22; agen 22 then 21 then 20 -> issue order 20, 21, 22, each with its own addr.
- Full: dispatch 4 ops -> disp_ready=0, occupancy=4; 5th dispatch ignored; one pop -> disp_ready=1 next cycle.
- Backpressure: instr_ready held low 5 cycles, then data_ready low 3 cycles -> valid and payload stable throughout, single pop.
- Bad agen: agen tag 99 with no entry, and a second agen for a resolved tag -> agen_err pulses one cycle each; state unchanged.
- Reset mid-DATA with 3 entries -> all outputs 0 immediately; occupancy 0; fresh dispatch after release issues normally.
